quickq_datapath: RTL and testbench

QUICKQ_DATAPATH -- requirements
Module: quickq_datapath

---
 rtl/quickq_pkg.sv | 20 ++
 rtl/quickq_regfile.sv | 64 ++++++
 rtl/quickq_datapath.sv | 151 +++++++++++++++
 tb/tb_quickq_datapath.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quickq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : quickq_pkg                                                  |
// | Purpose  : Shared constants for the quickq sorted-insert queue: key    |
// |            width, queue depth and the all-ones sentinel that marks an  |
// |            unused slot. Imported by the datapath, the storage and the  |
// |            external insert controller.                                 |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package quickq_pkg;

  localparam int DW    = 16;
  localparam int DEPTH = 16;

  // Largest representable key; also the "no entry here" marker, so it can
  // never be stored as a real key.
  localparam logic [DW-1:0] SENTINEL = '1;

endpackage : quickq_pkg
`default_nettype wire

// File: rtl/quickq_regfile.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : quickq_regfile                                              |
// | Purpose  : Circular key storage for quickq. Logical slot k lives at    |
// |            physical entry (head + k) mod DEPTH.                        |
// | Ports    : clk, rst_n      - clock, synchronous active-low reset       |
// |            head, offset    - circular base and logical slot index      |
// |            we, wr_head     - write enable; write at head (1) or at     |
// |                              head+offset (0)                           |
// |            wdata           - write data                                |
// |            rdata           - entry at head+offset, SENTINEL past end   |
// |            head_data       - entry at head                             |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module quickq_regfile #(
  parameter int DW    = quickq_pkg::DW,
  parameter int DEPTH = quickq_pkg::DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int OW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] head,
  input  logic [OW-1:0] offset,
  input  logic          we,
  input  logic          wr_head,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] head_data
);
  import quickq_pkg::*;

  localparam logic [DW-1:0] c_sentinel = '1;
  localparam logic [OW-1:0] c_end      = OW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];

  logic [AW-1:0] w_slot;
  logic          w_in_range;
  logic [AW-1:0] w_waddr;
  logic          w_wen;

  // DEPTH is a power of two, so the AW-bit add wraps modulo DEPTH for free.
  assign w_slot     = head + offset[AW-1:0];
  assign w_in_range = (offset != c_end);
  assign w_waddr    = wr_head ? head : w_slot;
  // A slot write past the last entry has nowhere to land and is dropped.
  assign w_wen      = we && (wr_head || w_in_range);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= c_sentinel;
      end
    end else if (w_wen) begin
      r_mem[w_waddr] <= wdata;
    end
  end

  assign rdata     = w_in_range ? r_mem[w_slot] : c_sentinel;
  assign head_data = r_mem[head];

endmodule : quickq_regfile
`default_nettype wire

// File: rtl/quickq_datapath.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : quickq_datapath                                             |
// | Purpose  : Datapath of a sorted priority queue. An external controller |
// |            loads a key into temp, then walks the slots comparing and   |
// |            swapping until temp holds SENTINEL (slot found) or the walk |
// |            runs off the end (largest key discarded).                   |
// | Ports    : clk, rst_n      - clock, synchronous active-low reset       |
// |            din             - key to enqueue                            |
// |            we              - write temp into current slot             |
// |            regenb, regsel  - temp load; source din (1) / slot (0)      |
// |            countenb        - advance slot offset                       |
// |            deq             - pop smallest key                          |
// |            done, result    - walk finished / temp < slot key           |
// |            head_data       - smallest stored key                       |
// |            count, empty, full - occupancy                              |
// |            ovf             - sticky: a key was discarded               |
// |            deq_err         - one-cycle pulse: deq rejected             |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module quickq_datapath #(
  parameter int DW    = quickq_pkg::DW,
  parameter int DEPTH = quickq_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            din,
  input  logic                     we,
  input  logic                     regenb,
  input  logic                     regsel,
  input  logic                     countenb,
  input  logic                     deq,
  output logic                     done,
  output logic                     result,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     deq_err
);
  import quickq_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  localparam logic [DW-1:0] c_sentinel = '1;
  localparam logic [OW-1:0] c_end      = OW'(DEPTH);

  logic [DW-1:0] r_temp;
  logic [AW-1:0] r_head;
  logic [OW-1:0] r_offset;
  logic [OW-1:0] r_count;
  logic          r_active;
  logic          r_ovf;
  logic          r_deq_err;

  logic [DW-1:0] w_rdata;
  logic          w_load;
  logic          w_at_end;
  logic          w_done;
  logic          w_full;
  logic          w_empty;
  logic          w_deq_ok;
  logic          w_rf_we;
  logic [DW-1:0] w_rf_wdata;

  assign w_load   = regenb && regsel;
  assign w_at_end = (r_offset == c_end);
  assign w_done   = (r_temp == c_sentinel) || w_at_end;
  assign w_full   = (r_count == c_end);
  assign w_empty  = (r_count == '0);

  // A pop is refused while an insert is walking or about to start, since
  // moving head would shift the logical slots under the walk.
  assign w_deq_ok = deq && !w_empty && !r_active && !regenb;

  // The single write port is shared: an accepted pop clears the head entry,
  // otherwise a slot write stores temp at head+offset.
  assign w_rf_we    = w_deq_ok || we;
  assign w_rf_wdata = w_deq_ok ? c_sentinel : r_temp;

  quickq_regfile #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .head      (r_head),
    .offset    (r_offset),
    .we        (w_rf_we),
    .wr_head   (w_deq_ok),
    .wdata     (w_rf_wdata),
    .rdata     (w_rdata),
    .head_data (head_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_temp    <= c_sentinel;
      r_head    <= '0;
      r_offset  <= '0;
      r_count   <= '0;
      r_active  <= 1'b0;
      r_ovf     <= 1'b0;
      r_deq_err <= 1'b0;
    end else begin
      if (w_load) begin
        r_temp   <= din;
        r_offset <= '0;
        r_active <= 1'b1;
        // When full the walk will push the largest key off the end, so the
        // occupancy stays at DEPTH.
        if ((din != c_sentinel) && !w_full) begin
          r_count <= r_count + OW'(1);
        end
      end else begin
        if (regenb) begin
          r_temp <= w_rdata;
        end
        if (countenb && !w_at_end) begin
          r_offset <= r_offset + OW'(1);
        end
        if (w_done) begin
          r_active <= 1'b0;
        end
        if (w_deq_ok) begin
          r_head  <= r_head + AW'(1);
          r_count <= r_count - OW'(1);
        end
      end

      // Walked past the last slot still holding a real key: it is lost.
      if (w_at_end && (r_temp != c_sentinel)) begin
        r_ovf <= 1'b1;
      end

      r_deq_err <= deq && !w_deq_ok;
    end
  end

  assign done    = w_done;
  assign result  = (r_temp < w_rdata);
  assign count   = r_count;
  assign empty   = w_empty;
  assign full    = w_full;
  assign ovf     = r_ovf;
  assign deq_err = r_deq_err;

endmodule : quickq_datapath
`default_nettype wire

// File: tb/tb_quickq_datapath.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_quickq_datapath                                          |
// | Purpose  : Self-checking bench for quickq_datapath. Drives the insert  |
// |            protocol, keeps a sorted scoreboard of expected keys and    |
// |            drains the queue comparing head_data against it.            |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_quickq_datapath;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam logic [DW-1:0] SENT = 16'hFFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          we, regenb, regsel, countenb, deq;
  logic          done, result;
  logic [DW-1:0] head_data;
  logic [CW-1:0] count;
  logic          empty, full, ovf, deq_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sb_q [$];

  always #5 clk = ~clk;

  quickq_datapath #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .we        (we),
    .regenb    (regenb),
    .regsel    (regsel),
    .countenb  (countenb),
    .deq       (deq),
    .done      (done),
    .result    (result),
    .head_data (head_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .deq_err   (deq_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    we = 1'b0; regenb = 1'b0; regsel = 1'b0; countenb = 1'b0; deq = 1'b0;
  endtask

  // Sorted insert; equal keys go behind existing ones; the largest key is
  // dropped once more than DEPTH are held.
  task automatic sb_push(input logic [DW-1:0] key);
    int i;
    if (key == SENT) return;
    i = 0;
    while (i < sb_q.size() && sb_q[i] <= key) i++;
    sb_q.insert(i, key);
    if (sb_q.size() > DEPTH) sb_q.delete(sb_q.size() - 1);
  endtask

  task automatic load_key(input logic [DW-1:0] key);
    din = key; regenb = 1'b1; regsel = 1'b1;
    tick;
    idle_inputs;
    sb_push(key);
  endtask

  // Controller behaviour: swap while temp < slot, otherwise step on.
  task automatic run_insert;
    bit fin;
    fin = 1'b0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      if (done === 1'b1) begin
        fin = 1'b1;
        break;
      end
      if (result === 1'b1) begin
        we = 1'b1; regenb = 1'b1; regsel = 1'b0; countenb = 1'b1;
      end else begin
        countenb = 1'b1;
      end
      tick;
      idle_inputs;
    end
    n_checks++;
    if (!fin) begin
      n_errors++;
      $display("FAIL insert_timeout: done=%b required 1", done);
    end
    tick;
  endtask

  task automatic insert(input logic [DW-1:0] key);
    load_key(key);
    run_insert;
  endtask

  task automatic drain(input string tag);
    logic [DW-1:0] exp;
    for (int i = 0; i < DEPTH + 2 && empty !== 1'b1; i++) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL %s_extra: head_data=%h required queue empty", tag, head_data);
      end else begin
        exp = sb_q.pop_front();
        if (head_data !== exp) begin
          n_errors++;
          $display("FAIL %s_order: head_data=%h required %h", tag, head_data, exp);
        end
      end
      deq = 1'b1;
      tick;
      deq = 1'b0;
      n_checks++;
      if (deq_err !== 1'b0) begin
        n_errors++;
        $display("FAIL %s_deq_err: deq_err=%b required 0", tag, deq_err);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_end: empty=%b entries_left_in_model=%0d required empty=1 and 0", tag, empty, sb_q.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; din = '0; idle_inputs;
    tick; tick;
    rst_n = 1'b1;
    sb_q.delete();
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_occupancy: count=%0d empty=%b full=%b required 0 1 0", count, empty, full);
    end
    n_checks++;
    if (ovf !== 1'b0 || deq_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: ovf=%b deq_err=%b required 0 0", ovf, deq_err);
    end
    n_checks++;
    if (head_data !== SENT || done !== 1'b1 || result !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_data: head_data=%h done=%b result=%b required ffff 1 0", head_data, done, result);
    end
  endtask

  task automatic test_single_swap;
    load_key(16'h0005);
    n_checks++;
    if (result !== 1'b1 || done !== 1'b0 || count !== 5'd1) begin
      n_errors++;
      $display("FAIL swap_compare: result=%b done=%b count=%0d required 1 0 1", result, done, count);
    end
    we = 1'b1; regenb = 1'b1; countenb = 1'b1;
    tick;
    idle_inputs;
    n_checks++;
    if (done !== 1'b1 || count !== 5'd1 || head_data !== 16'h0005) begin
      n_errors++;
      $display("FAIL swap_after: done=%b count=%0d head_data=%h required 1 1 0005", done, count, head_data);
    end
    tick;
    drain("swap");
  endtask

  task automatic test_sorted_insert;
    insert(16'h0030);
    insert(16'h0010);
    insert(16'h0020);
    n_checks++;
    if (count !== 5'd3 || head_data !== 16'h0010) begin
      n_errors++;
      $display("FAIL sorted_state: count=%0d head_data=%h required 3 0010", count, head_data);
    end
    drain("sorted");
  endtask

  task automatic test_sentinel_insert;
    insert(16'h0042);
    load_key(SENT);
    n_checks++;
    if (done !== 1'b1 || count !== 5'd1) begin
      n_errors++;
      $display("FAIL sentinel_insert: done=%b count=%0d required 1 1", done, count);
    end
    tick;
    drain("sentinel");
  endtask

  task automatic test_overflow;
    for (int k = 1; k <= DEPTH; k++) insert(DW'(k));
    n_checks++;
    if (full !== 1'b1 || count !== 5'd16 || ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL fill_state: full=%b count=%0d ovf=%b required 1 16 0", full, count, ovf);
    end
    insert(16'h0000);
    n_checks++;
    if (ovf !== 1'b1 || count !== 5'd16 || head_data !== 16'h0000) begin
      n_errors++;
      $display("FAIL ovf_state: ovf=%b count=%0d head_data=%h required 1 16 0000", ovf, count, head_data);
    end
    drain("ovf");
    n_checks++;
    if (ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_sticky: ovf=%b required 1", ovf);
    end
  endtask

  task automatic test_reset_mid_swap;
    insert(16'h0050);
    insert(16'h0060);
    load_key(16'h0040);
    we = 1'b1; regenb = 1'b1; countenb = 1'b1; rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    idle_inputs;
    sb_q.delete();
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || done !== 1'b1 || ovf !== 1'b0 || head_data !== SENT) begin
      n_errors++;
      $display("FAIL reset_mid_swap: count=%0d empty=%b done=%b ovf=%b head_data=%h required 0 1 1 0 ffff",
               count, empty, done, ovf, head_data);
    end
    insert(16'h0077);
    drain("post_reset");
  endtask

  task automatic test_deq;
    insert(16'h0007);
    insert(16'h0003);
    insert(16'h0009);
    deq = 1'b1;
    tick;
    deq = 1'b0;
    void'(sb_q.pop_front());
    n_checks++;
    if (head_data !== 16'h0007 || count !== 5'd2 || deq_err !== 1'b0) begin
      n_errors++;
      $display("FAIL deq_one: head_data=%h count=%0d deq_err=%b required 0007 2 0", head_data, count, deq_err);
    end
    drain("deq");
    deq = 1'b1;
    tick;
    deq = 1'b0;
    n_checks++;
    if (deq_err !== 1'b1 || count !== 5'd0 || empty !== 1'b1 || head_data !== SENT) begin
      n_errors++;
      $display("FAIL deq_empty: deq_err=%b count=%0d empty=%b head_data=%h required 1 0 1 ffff",
               deq_err, count, empty, head_data);
    end
    tick;
    n_checks++;
    if (deq_err !== 1'b0) begin
      n_errors++;
      $display("FAIL deq_err_pulse: deq_err=%b required 0", deq_err);
    end
  endtask

  task automatic test_deq_mid_insert;
    insert(16'h0100);
    insert(16'h0300);
    load_key(16'h0200);
    // temp 0200 vs slot 0100: step on, with a pop request riding along.
    countenb = 1'b1; deq = 1'b1;
    tick;
    idle_inputs;
    n_checks++;
    if (deq_err !== 1'b1 || count !== 5'd3) begin
      n_errors++;
      $display("FAIL deq_mid_insert: deq_err=%b count=%0d required 1 3", deq_err, count);
    end
    run_insert;
    n_checks++;
    if (count !== 5'd3 || head_data !== 16'h0100) begin
      n_errors++;
      $display("FAIL mid_insert_done: count=%0d head_data=%h required 3 0100", count, head_data);
    end
    drain("mid_insert");
  endtask

  initial begin
    test_reset;
    test_single_swap;
    test_sorted_insert;
    test_sentinel_insert;
    test_overflow;
    test_reset_mid_swap;
    test_deq;
    test_deq_mid_insert;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_quickq_datapath
`default_nettype wire
